// File: rtl/dec_int_entry.sv
// ============================================================================
// Module   : dec_int_entry
// Brief    : Key-token decimal accumulator producing a saturating signed
//            64-bit integer through a valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_int_entry (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [3:0]  in_digit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_int,
    output logic        out_ovf
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0]  c_KIND_DIGIT = 2'b00;
    localparam logic [1:0]  c_KIND_MINUS = 2'b01;
    localparam logic [1:0]  c_KIND_ENTER = 2'b10;
    localparam logic [1:0]  c_KIND_CLEAR = 2'b11;
    localparam logic [64:0] c_MAG_LIMIT  = 65'h0_8000_0000_0000_0000;
    localparam logic [63:0] c_INT_MIN    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_INT_MAX    = 64'h7FFF_FFFF_FFFF_FFFF;

    state_t        state_q, state_d;
    logic [64:0]   mag_q, mag_d;
    logic          neg_q, neg_d;
    logic          ovf_q, ovf_d;
    logic [63:0]   out_int_q, out_int_d;
    logic          out_ovf_q, out_ovf_d;

    logic          w_accept;
    logic          w_digit_ok;
    logic [68:0]   w_next;
    logic          w_fovf;
    logic [63:0]   w_result;

    assign in_ready   = (state_q != S_DONE);
    assign out_valid  = (state_q == S_DONE);
    assign out_int    = out_int_q;
    assign out_ovf    = out_ovf_q;

    assign w_accept   = in_valid & in_ready;
    assign w_digit_ok = (in_kind == c_KIND_DIGIT) && (in_digit <= 4'd9);

    // mag*10 + d without a multiplier; 69 bits cannot wrap for mag <= 2^63
    assign w_next = ({4'b0, mag_q} << 3) + ({4'b0, mag_q} << 1) + {65'b0, in_digit};

    // +2^63 is not representable, so only the negative side may reach it
    assign w_fovf   = ovf_q | (~neg_q & (mag_q == c_MAG_LIMIT));
    assign w_result = w_fovf ? (neg_q ? c_INT_MIN : c_INT_MAX)
                             : (neg_q ? (64'd0 - mag_q[63:0]) : mag_q[63:0]);

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        out_int_d = out_int_q;
        out_ovf_d = out_ovf_q;
        case (state_q)
            S_EMPTY: begin
                if (w_accept) begin
                    case (in_kind)
                        c_KIND_DIGIT: begin
                            if (w_digit_ok) begin
                                mag_d   = {61'b0, in_digit};
                                state_d = S_ACCUM;
                            end
                        end
                        c_KIND_MINUS: neg_d = ~neg_q;
                        c_KIND_ENTER: begin
                            out_int_d = w_result;
                            out_ovf_d = w_fovf;
                            state_d   = S_DONE;
                        end
                        default:      neg_d = 1'b0;
                    endcase
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    case (in_kind)
                        c_KIND_DIGIT: begin
                            if (w_digit_ok) begin
                                if (ovf_q || (w_next > {4'b0, c_MAG_LIMIT})) begin
                                    ovf_d = 1'b1;
                                end else begin
                                    mag_d = w_next[64:0];
                                end
                            end
                        end
                        c_KIND_ENTER: begin
                            out_int_d = w_result;
                            out_ovf_d = w_fovf;
                            state_d   = S_DONE;
                        end
                        c_KIND_CLEAR: begin
                            mag_d   = 65'd0;
                            neg_d   = 1'b0;
                            ovf_d   = 1'b0;
                            state_d = S_EMPTY;
                        end
                        default: ;
                    endcase
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    mag_d   = 65'd0;
                    neg_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            mag_q     <= 65'd0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            out_int_q <= 64'd0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            out_int_q <= out_int_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dec_int_entry.sv
// ============================================================================
// Module   : tb_dec_int_entry
// Brief    : Directed key-sequence vectors and handshake corner cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_int_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = 2'b00;
    logic [3:0]  in_digit = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_int;
    logic        out_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    dec_int_entry dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_digit  (in_digit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [191:0] keys;   // '-' minus, '=' enter, 'c' clear, 'x' digit 12
        logic [63:0]  exp;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic run_keys(input logic [191:0] keys);
        logic [7:0] c;
        for (int i = 23; i >= 0; i--) begin
            c = keys[i*8 +: 8];
            if (c == 8'd0) continue;
            @(negedge clk);
            in_valid = 1'b1;
            in_digit = 4'd0;
            if (c == "-")      in_kind = 2'b01;
            else if (c == "=") in_kind = 2'b10;
            else if (c == "c") in_kind = 2'b11;
            else if (c == "x") begin in_kind = 2'b00; in_digit = 4'd12; end
            else begin in_kind = 2'b00; in_digit = 4'(c - "0"); end
            if (c == "=") check("valid_before_enter", {63'd0, out_valid}, 64'd0);
            @(posedge clk);
        end
    endtask

    task automatic finish_check(input string name, input logic [63:0] exp, input logic exp_ovf);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({name, "_int"}, out_int, exp);
        check({name, "_ovf"}, {63'd0, out_ovf}, {63'd0, exp_ovf});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_drop"}, {63'd0, out_valid}, 64'd0);
        check({name, "_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_valid"}, {63'd0, out_valid}, 64'd0);
        check({name, "_int"}, out_int, 64'd0);
        check({name, "_ovf"}, {63'd0, out_ovf}, 64'd0);
        check({name, "_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        vecs[0]  = '{keys: "123=",                   exp: 64'd123,                 exp_ovf: 1'b0};
        vecs[1]  = '{keys: "-9223372036854775808=",  exp: 64'h8000_0000_0000_0000, exp_ovf: 1'b0};
        vecs[2]  = '{keys: "9223372036854775808=",   exp: 64'h7FFF_FFFF_FFFF_FFFF, exp_ovf: 1'b1};
        vecs[3]  = '{keys: "-99999999999999999999=", exp: 64'h8000_0000_0000_0000, exp_ovf: 1'b1};
        vecs[4]  = '{keys: "4-x2=",                  exp: 64'd42,                  exp_ovf: 1'b0};
        vecs[5]  = '{keys: "--7=",                   exp: 64'd7,                   exp_ovf: 1'b0};
        vecs[6]  = '{keys: "=",                      exp: 64'd0,                   exp_ovf: 1'b0};
        vecs[7]  = '{keys: "-0=",                    exp: 64'd0,                   exp_ovf: 1'b0};
        vecs[8]  = '{keys: "5c8=",                   exp: 64'd8,                   exp_ovf: 1'b0};
        vecs[9]  = '{keys: "9223372036854775807=",   exp: 64'h7FFF_FFFF_FFFF_FFFF, exp_ovf: 1'b0};
        vecs[10] = '{keys: "92233720368547758070=",  exp: 64'h7FFF_FFFF_FFFF_FFFF, exp_ovf: 1'b1};
        vecs[11] = '{keys: "-9223372036854775809=",  exp: 64'h8000_0000_0000_0000, exp_ovf: 1'b1};
        vecs[12] = '{keys: "c-c5=",                  exp: 64'd5,                   exp_ovf: 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        for (int i = 0; i < 13; i++) begin
            run_keys(vecs[i].keys);
            finish_check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_ovf);
        end

        // Back-pressure: result held, tokens refused while out_ready is low
        run_keys("-5=");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_kind  = 2'b00;
            in_digit = 4'd7;
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_int", out_int, 64'hFFFF_FFFF_FFFF_FFFB);
            check("hold_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("hold_release_int", out_int, 64'hFFFF_FFFF_FFFF_FFFB);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_after_valid", {63'd0, out_valid}, 64'd0);
        check("hold_after_ready", {63'd0, in_ready}, 64'd1);
        run_keys("=");
        finish_check("hold_no_consume", 64'd0, 1'b0);

        // Reset mid-entry, with a token offered in the same cycle
        run_keys("33");
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_kind  = 2'b00;
        in_digit = 4'd9;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset_state("rst_accum");
        run_keys("1=");
        finish_check("after_rst_accum", 64'd1, 1'b0);

        // Reset in DONE wins over a simultaneous out_ready
        run_keys("77=");
        @(negedge clk);
        in_valid  = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        check_reset_state("rst_done");
        run_keys("1=");
        finish_check("after_rst_done", 64'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
